// File: rtl/fc_layer_ctrl.sv
// Sequencer for one fully-connected layer: broadcasts the input word stream to the neurons,
// steps the shared weight/bias controls, then serializes the neuron outputs to the next layer.
module fc_layer_ctrl #(
    parameter int WORD_SIZE             = 16,
    parameter int PREVIOUS_LAYER_HEIGHT = 4,
    parameter int LAYER_HEIGHT          = 4,
    localparam int AW = $clog2(PREVIOUS_LAYER_HEIGHT + 1),
    localparam int OW = $clog2(LAYER_HEIGHT + 1)
) (
    input  logic                           clk_i,
    input  logic                           reset_i,
    input  logic [WORD_SIZE-1:0]           data_i,
    input  logic                           valid_i,
    output logic                           ready_o,
    output logic [WORD_SIZE-1:0]           neuron_data_o,
    output logic [AW-1:0]                  mem_addr_o,
    output logic                           sum_en_o,
    output logic                           add_bias_o,
    output logic                           clear_o,
    input  logic [LAYER_HEIGHT*WORD_SIZE-1:0] neuron_out_i,
    output logic [WORD_SIZE-1:0]           data_o,
    output logic                           valid_o,
    input  logic                           ready_i
);

    // Both streams use valid/ready: a word moves only in a cycle where valid and ready are
    // both high; valid held without ready (or ready without valid) changes nothing.
    typedef enum logic [1:0] {
        eBUSY = 2'd0,
        eBIAS = 2'd1,
        eOUT  = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [AW-1:0]       in_cnt_q, in_cnt_d;
    logic [OW-1:0]       out_cnt_q, out_cnt_d;
    logic [WORD_SIZE-1:0] word_sel;

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q   <= eBUSY;
            in_cnt_q  <= '0;
            out_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            in_cnt_q  <= in_cnt_d;
            out_cnt_q <= out_cnt_d;
        end
    end

    always_comb begin
        word_sel = '0;
        for (int k = 0; k < LAYER_HEIGHT; k++) begin
            if (out_cnt_q == OW'(k)) begin
                word_sel = neuron_out_i[k*WORD_SIZE +: WORD_SIZE];
            end
        end
    end

    assign neuron_data_o = data_i;

    always_comb begin
        state_d    = state_q;
        in_cnt_d   = in_cnt_q;
        out_cnt_d  = out_cnt_q;
        ready_o    = 1'b0;
        valid_o    = 1'b0;
        mem_addr_o = '0;
        sum_en_o   = 1'b0;
        add_bias_o = 1'b0;
        clear_o    = 1'b0;
        data_o     = '0;
        case (state_q)
            eBUSY: begin
                ready_o    = 1'b1;
                mem_addr_o = in_cnt_q;
                sum_en_o   = valid_i;
                if (valid_i) begin
                    if (in_cnt_q == AW'(PREVIOUS_LAYER_HEIGHT - 1)) begin
                        in_cnt_d = '0;
                        state_d  = eBIAS;
                    end else begin
                        in_cnt_d = in_cnt_q + AW'(1);
                    end
                end
            end
            eBIAS: begin
                mem_addr_o = AW'(PREVIOUS_LAYER_HEIGHT);
                sum_en_o   = 1'b1;
                add_bias_o = 1'b1;
                state_d    = eOUT;
            end
            eOUT: begin
                // Neuron sums stay frozen while their outputs are read out one by one.
                valid_o = 1'b1;
                data_o  = word_sel;
                if (ready_i) begin
                    if (out_cnt_q == OW'(LAYER_HEIGHT - 1)) begin
                        clear_o   = 1'b1;
                        out_cnt_d = '0;
                        state_d   = eBUSY;
                    end else begin
                        out_cnt_d = out_cnt_q + OW'(1);
                    end
                end
            end
            default: state_d = eBUSY;
        endcase
    end

endmodule

// File: tb/tb_fc_layer_ctrl.sv
// Bench for fc_layer_ctrl (4 inputs, 2 neurons): directed scenarios plus random traffic,
// each cycle compared against a frame-level model built from a word count and an output queue.
module tb_fc_layer_ctrl;
  localparam int W  = 16;
  localparam int P  = 4;
  localparam int L  = 2;
  localparam int AW = $clog2(P + 1);

  logic           clk = 1'b0;
  logic           rst;
  logic [W-1:0]   data_i;
  logic           valid_i;
  logic           ready_o;
  logic [W-1:0]   neuron_data_o;
  logic [AW-1:0]  mem_addr_o;
  logic           sum_en_o;
  logic           add_bias_o;
  logic           clear_o;
  logic [L*W-1:0] neuron_out_i;
  logic [W-1:0]   data_o;
  logic           valid_o;
  logic           ready_i;

  fc_layer_ctrl #(.WORD_SIZE(W), .PREVIOUS_LAYER_HEIGHT(P), .LAYER_HEIGHT(L)) dut (
    .clk_i(clk), .reset_i(rst), .data_i(data_i), .valid_i(valid_i), .ready_o(ready_o),
    .neuron_data_o(neuron_data_o), .mem_addr_o(mem_addr_o), .sum_en_o(sum_en_o),
    .add_bias_o(add_bias_o), .clear_o(clear_o), .neuron_out_i(neuron_out_i),
    .data_o(data_o), .valid_o(valid_o), .ready_i(ready_i)
  );

  // clock / reset
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // model: words accepted in the current frame, pending bias cycle, queue of words still owed downstream
  int           n_in;
  bit           bias_pending;
  logic [W-1:0] exp_q[$];
  int           frames_out;

  typedef struct packed {
    logic          rdy;
    logic          vld;
    logic [AW-1:0] addr;
    logic          sum;
    logic          bias;
    logic          clr;
    logic [W-1:0]  dout;
    logic [W-1:0]  bcast;
  } obs_t;

  obs_t exp_s;
  obs_t obs_s;

  function automatic void model_reset();
    n_in = 0;
    bias_pending = 0;
    exp_q.delete();
  endfunction

  function automatic void predict();
    exp_s = '0;
    exp_s.bcast = data_i;
    if (exp_q.size() > 0) begin
      exp_s.vld  = 1'b1;
      exp_s.dout = exp_q[0];
      exp_s.clr  = ready_i && (exp_q.size() == 1);
    end else if (bias_pending) begin
      exp_s.addr = AW'(P);
      exp_s.sum  = 1'b1;
      exp_s.bias = 1'b1;
    end else begin
      exp_s.rdy  = 1'b1;
      exp_s.addr = AW'(n_in);
      exp_s.sum  = valid_i;
    end
    obs_s = {ready_o, valid_o, mem_addr_o, sum_en_o, add_bias_o, clear_o,
             (exp_s.vld ? data_o : {W{1'b0}}), neuron_data_o};
  endfunction

  function automatic void commit();
    if (exp_q.size() > 0) begin
      if (ready_i) begin
        void'(exp_q.pop_front());
        if (exp_q.size() == 0) frames_out++;
      end
    end else if (bias_pending) begin
      bias_pending = 0;
      for (int k = 0; k < L; k++) exp_q.push_back(neuron_out_i[k*W +: W]);
    end else if (valid_i) begin
      n_in++;
      if (n_in == P) begin
        n_in = 0;
        bias_pending = 1;
      end
    end
  endfunction

  // driver: inputs change on the falling edge, outputs are sampled 1 ns later
  task automatic apply(input logic v, input logic [W-1:0] d, input logic r);
    @(negedge clk);
    valid_i = v;
    data_i  = d;
    ready_i = r;
    if (exp_q.size() == 0 && !bias_pending) neuron_out_i = {$urandom, $urandom};
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; valid_i = 1'b0; ready_i = 1'b0; data_i = '0;
    neuron_out_i = {$urandom, $urandom};
    model_reset();
    repeat (3) @(negedge clk);
    #1;
    predict();
    checks++;
    if (obs_s !== exp_s) begin
      failures++;
      $display("FAIL reset_held got=%h want=%h", obs_s, exp_s);
    end
    @(negedge clk);
    rst = 1'b0;
    apply(1'b0, '0, 1'b0);
    predict();
    checks++;
    if (obs_s !== exp_s) begin
      failures++;
      $display("FAIL reset_release got=%h want=%h", obs_s, exp_s);
    end
    commit();
  endtask

  task automatic test_back_to_back();
    for (int c = 0; c < 8; c++) begin
      apply(c < P, W'(c + 1), 1'b1);
      predict();
      checks++;
      if (obs_s !== exp_s) begin
        failures++;
        $display("FAIL back_to_back cyc=%0d got=%h want=%h", c, obs_s, exp_s);
      end
      commit();
    end
  endtask

  task automatic test_bubbles();
    logic [6:0] pat;
    pat = 7'b1011001;
    for (int c = 0; c < 12; c++) begin
      apply((c < 7) ? pat[c] : 1'b0, W'($urandom), 1'b1);
      predict();
      checks++;
      if (obs_s !== exp_s) begin
        failures++;
        $display("FAIL bubbles cyc=%0d got=%h want=%h", c, obs_s, exp_s);
      end
      commit();
    end
  endtask

  task automatic test_backpressure();
    // 4 inputs, bias, word0 taken, 5 stalled cycles, word1 taken, then back in the input phase
    for (int c = 0; c < 13; c++) begin
      apply(1'b1, W'($urandom), !(c >= 6 && c <= 10));
      predict();
      checks++;
      if (obs_s !== exp_s) begin
        failures++;
        $display("FAIL backpressure cyc=%0d got=%h want=%h", c, obs_s, exp_s);
      end
      commit();
    end
    // drain the frame started in the last cycle so later tests start aligned
    for (int c = 0; c < 8 && (n_in != 0 || bias_pending || exp_q.size() > 0); c++) begin
      apply(!bias_pending && exp_q.size() == 0, W'($urandom), 1'b1);
      predict();
      checks++;
      if (obs_s !== exp_s) begin
        failures++;
        $display("FAIL drain cyc=%0d got=%h want=%h", c, obs_s, exp_s);
      end
      commit();
    end
  endtask

  task automatic test_reset_mid_frame();
    for (int c = 0; c < 2; c++) begin
      apply(1'b1, W'($urandom), 1'b0);
      predict();
      checks++;
      if (obs_s !== exp_s) begin
        failures++;
        $display("FAIL mid_pre cyc=%0d got=%h want=%h", c, obs_s, exp_s);
      end
      commit();
    end
    @(negedge clk);
    rst = 1'b1; valid_i = 1'b0;
    #1;
    model_reset();
    predict();
    checks++;
    if (obs_s !== exp_s) begin
      failures++;
      $display("FAIL mid_reset got=%h want=%h", obs_s, exp_s);
    end
    @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 8; c++) begin
      apply(c < P, W'($urandom), 1'b1);
      predict();
      checks++;
      if (obs_s !== exp_s) begin
        failures++;
        $display("FAIL mid_post cyc=%0d got=%h want=%h", c, obs_s, exp_s);
      end
      commit();
    end
  endtask

  task automatic test_random();
    int start_frames;
    start_frames = frames_out;
    for (int c = 0; c < 600; c++) begin
      apply(1'($urandom_range(0, 1)), W'($urandom), 1'($urandom_range(0, 1)));
      predict();
      checks++;
      if (obs_s !== exp_s) begin
        failures++;
        $display("FAIL random cyc=%0d got=%h want=%h", c, obs_s, exp_s);
      end
      commit();
    end
    checks++;
    if (frames_out - start_frames < 10) begin
      failures++;
      $display("FAIL random_progress frames=%0d want>=10", frames_out - start_frames);
    end
  endtask

  initial begin
    frames_out = 0;
    test_reset();
    test_back_to_back();
    test_bubbles();
    test_backpressure();
    test_reset_mid_frame();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
